reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised successor to the single-write, dual-read register file, for the pipelined CPU datapath.
- Adds configurable width, depth and read-port count.
- Adds a second write port with byte strobes and a per-register busy scoreboard for hazard detection.
- Register 0 is hardwired to zero. Reads are combinational; writes and scoreboard updates occur on the rising clock edge.

Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH.
- NUM_RD, 2, number of read ports (1..4).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset.
- wen0  input  1  write enable, port 0.
- waddr0  input  ADDR_WIDTH  write address, port 0.
- wstrb0  input  DATA_WIDTH/8  byte strobes, port 0.
- wdata0  input  DATA_WIDTH  write data, port 0.
- wen1  input  1  write enable, port 1.
- waddr1  input  ADDR_WIDTH  write address, port 1.
- wstrb1  input  DATA_WIDTH/8  byte strobes, port 1.
- wdata1  input  DATA_WIDTH  write data, port 1.
- raddr  input  NUM_RD*ADDR_WIDTH  packed read addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  output  NUM_RD*DATA_WIDTH  packed read data, same packing.
- rbusy  output  NUM_RD  busy flag of the register addressed by each read port.
- bset  input  1  mark register bset_addr busy (a producer was issued).
- bset_addr  input  ADDR_WIDTH  register to mark busy.

Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset: while rst_n=0, all registers clear to 0 and all busy bits clear to 0, independent of clk.
  - rdata therefore reads 0 and rbusy reads 0 for every port.
  - Deassertion takes effect at the next rising edge.
  - Reset asserted mid-write aborts that write; the register reads 0.
- Read: rdata[k] = mem[raddr[k]], combinational, zero latency. Address 0 always returns 0.
- Write: at a rising edge, for each port p with wen_p=1 and waddr_p!=0, byte b of mem[waddr_p] <= wdata_p byte b where wstrb_p[b]=1. Bytes with strobe 0 are unchanged.
- Write conflict: wen0 and wen1 target the same nonzero address → resolved per byte; port 1 wins for bytes where both strobes are 1, each port writes its own bytes otherwise.
- Write latency: new data is visible on rdata in the cycle after the edge (without RF_BYPASS_EN).
- Busy scoreboard:
  - Clear: at the edge, busy[waddr_p] <= 0 for any port with wen_p=1, regardless of wstrb.
  - Set: busy[bset_addr] <= 1 when bset=1 and bset_addr!=0.
  - Same-cycle set and clear on one register → set wins (a new producer supersedes).
  - busy[0] is constant 0.
  - rbusy[k] = busy[raddr[k]], combinational.
- Zero-strobe write: wen=1 with wstrb=0 changes no data but still clears busy. Used for retire-without-write.
- No internal state beyond the mem array and the busy vector; no handshakes. Callers guarantee address stability around the edge.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding.
  - If a read address matches an enabled nonzero write address in the current cycle, rdata returns the merged value: old contents, overlaid by port 0 strobed bytes, then port 1 strobed bytes.
  - rbusy returns 0 for a register being cleared this cycle unless bset targets it in the same cycle.
- Undefined: reads return stored contents only. Forwarding is the pipeline's responsibility.

Test Plan:
- Reset, then write via port 0 with wstrb0=4'hF: wdata0=i to register i for i=0..31. Read all pairs on two ports → register 0 reads 0, register i reads i.
- Write reg 5 = 32'hAABBCCDD, then a port 1 write with wstrb1=4'b0101, wdata1=32'h11223344 → reg 5 reads 32'hAA22CC44.
- Same-cycle conflict on reg 7:
  - port 0 wstrb=4'hF, data 32'h00000000;
  - port 1 wstrb=4'b1000, data 32'hFF000000;
  - → reg 7 reads 32'hFF000000.
- Scoreboard:
  - bset reg 9 → rbusy=1 next cycle;
  - a wen0 write to reg 9 with bset to reg 9 in the same cycle → still busy;
  - a later write alone → rbusy=0;
  - bset on reg 0 → rbusy stays 0.
- Assert rst_n=0 asynchronously between edges after loading registers → rdata and rbusy are 0 immediately, before the next clk edge.
- With RF_BYPASS_EN: write reg 3=32'h12345678 while raddr port 1=3 → rdata port 1 shows 32'h12345678 in the same cycle. Without the macro, it shows the old value until the next cycle.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file with byte-strobed
// dual write ports and a busy scoreboard. Optional macro: RF_BYPASS_EN.
module reg_file_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_RD     = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wen0,
   input  logic [ADDR_WIDTH-1:0]        waddr0,
   input  logic [DATA_WIDTH/8-1:0]      wstrb0,
   input  logic [DATA_WIDTH-1:0]        wdata0,
   input  logic                         wen1,
   input  logic [ADDR_WIDTH-1:0]        waddr1,
   input  logic [DATA_WIDTH/8-1:0]      wstrb1,
   input  logic [DATA_WIDTH-1:0]        wdata1,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
   output logic [NUM_RD-1:0]            rbusy,
   input  logic                         bset,
   input  logic [ADDR_WIDTH-1:0]        bset_addr
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int NB    = DATA_WIDTH/8;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]      busy;
   logic [DEPTH-1:0]      busy_nxt;

   // old contents overlaid by port 0 bytes, then port 1 bytes
   function automatic logic [DATA_WIDTH-1:0] merge(
      input logic [ADDR_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] old
   );
      logic [DATA_WIDTH-1:0] v;
      v = old;
      if (a != '0) begin
         for (int b = 0; b < NB; b++) begin
            if (wen0 && waddr0 == a && wstrb0[b])
               v[b*8 +: 8] = wdata0[b*8 +: 8];
         end
         for (int b = 0; b < NB; b++) begin
            if (wen1 && waddr1 == a && wstrb1[b])
               v[b*8 +: 8] = wdata1[b*8 +: 8];
         end
      end
      return v;
   endfunction

   // storage update: strobed byte writes, register 0 pinned to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         mem[0] <= '0;
         for (int i = 1; i < DEPTH; i++)
            mem[i] <= merge(ADDR_WIDTH'(i), mem[i]);
      end
   end

   // scoreboard next state: writes retire, a new producer set wins
   always_comb begin
      busy_nxt = busy;
      if (wen0) busy_nxt[waddr0] = 1'b0;
      if (wen1) busy_nxt[waddr1] = 1'b0;
      if (bset) busy_nxt[bset_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // scoreboard register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

   // combinational read ports
   always_comb begin
      rdata = '0;
      rbusy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         logic [ADDR_WIDTH-1:0] a;
         a = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef RF_BYPASS_EN
         rdata[k*DATA_WIDTH +: DATA_WIDTH] =
            (a == '0) ? '0 : merge(a, mem[a]);
         if ((wen0 && waddr0 == a) || (wen1 && waddr1 == a))
            rbusy[k] = bset && bset_addr == a && a != '0;
         else
            rbusy[k] = busy[a];
`else
         rdata[k*DATA_WIDTH +: DATA_WIDTH] =
            (a == '0) ? '0 : mem[a];
         rbusy[k] = busy[a];
`endif
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: table-driven and scoreboard checks for reg_file_mp.
// Expectations adapt to RF_BYPASS_EN.
module tb_reg_file_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int NB = DW/8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wen0, wen1, bset;
   logic [AW-1:0] waddr0, waddr1, bset_addr;
   logic [NB-1:0] wstrb0, wstrb1;
   logic [DW-1:0] wdata0, wdata1;
   logic [NR*AW-1:0] raddr;
   logic [NR*DW-1:0] rdata;
   logic [NR-1:0]    rbusy;

   reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
      .clk(clk), .rst_n(rst_n),
      .wen0(wen0), .waddr0(waddr0), .wstrb0(wstrb0), .wdata0(wdata0),
      .wen1(wen1), .waddr1(waddr1), .wstrb1(wstrb1), .wdata1(wdata1),
      .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .bset(bset), .bset_addr(bset_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         nm;
      int            port;
      logic [DW-1:0] d;
      logic          b;
   } exp_t;

   typedef struct {
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
   } vec_t;

   exp_t sbq[$];
   vec_t tbl[32];
   int   total = 0;
   int   bad = 0;

   task automatic rd(input int port, input logic [AW-1:0] a);
      raddr[port*AW +: AW] = a;
   endtask

   task automatic expect_rd(input string nm, input int port,
                            input logic [DW-1:0] d, input logic b);
      exp_t e;
      e.nm = nm; e.port = port; e.d = d; e.b = b;
      sbq.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      logic [DW-1:0] gd;
      logic gb;
      #1;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         gd = rdata[e.port*DW +: DW];
         gb = rbusy[e.port];
         total++;
         if (gd !== e.d || gb !== e.b) begin
            bad++;
            $display("FAIL %s port%0d: got data=%h busy=%b want data=%h busy=%b",
                     e.nm, e.port, gd, gb, e.d, e.b);
         end
      end
   endtask

   task automatic wr(input int p, input logic [AW-1:0] a,
                     input logic [NB-1:0] s, input logic [DW-1:0] d);
      if (p == 0) begin
         wen0 = 1'b1; waddr0 = a; wstrb0 = s; wdata0 = d;
      end else begin
         wen1 = 1'b1; waddr1 = a; wstrb1 = s; wdata1 = d;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      wen0 = 1'b0; wen1 = 1'b0; bset = 1'b0;
   endtask

   logic [DW-1:0] by_exp;

   initial begin
      rst_n = 1'b1;
      wen0 = 0; wen1 = 0; bset = 0;
      waddr0 = '0; waddr1 = '0; bset_addr = '0;
      wstrb0 = '0; wstrb1 = '0; wdata0 = '0; wdata1 = '0;
      raddr = '0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);

      // reset state
      for (int i = 0; i < 32; i += 8) begin
         rd(0, AW'(i)); rd(1, AW'(i + 5));
         expect_rd("reset_state", 0, '0, 1'b0);
         expect_rd("reset_state", 1, '0, 1'b0);
         drain();
      end
      @(negedge clk);
      rst_n = 1'b1;

      // fill register i with i
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         wr(0, AW'(i), 4'hF, DW'(i));
         tick();
      end
      @(negedge clk);
      wr(0, '0, 4'hF, 32'hFFFF_FFFF);
      tick();

      for (int i = 0; i < 32; i++) begin
         tbl[i].a0 = AW'(i);
         tbl[i].a1 = AW'(31 - i);
         tbl[i].d0 = DW'(i);
         tbl[i].d1 = DW'(31 - i);
      end
      for (int i = 0; i < 32; i++) begin
         rd(0, tbl[i].a0); rd(1, tbl[i].a1);
         expect_rd("fill_rd", 0, tbl[i].d0, 1'b0);
         expect_rd("fill_rd", 1, tbl[i].d1, 1'b0);
         drain();
      end

      // byte strobes on port 1
      @(negedge clk);
      wr(0, 5'd5, 4'hF, 32'hAABB_CCDD);
      tick();
      @(negedge clk);
      wr(1, 5'd5, 4'b0101, 32'h1122_3344);
      tick();
      rd(0, 5'd5);
      expect_rd("strobe_merge", 0, 32'hAA22_CC44, 1'b0);
      drain();

      // same-cycle conflict, full overlap on byte 3
      @(negedge clk);
      wr(0, 5'd7, 4'hF, 32'h0000_0000);
      wr(1, 5'd7, 4'b1000, 32'hFF00_0000);
      tick();
      rd(1, 5'd7);
      expect_rd("conflict_p1_wins", 1, 32'hFF00_0000, 1'b0);
      drain();

      // same-cycle conflict, disjoint strobes
      @(negedge clk);
      wr(0, 5'd8, 4'b0011, 32'h1111_BEEF);
      wr(1, 5'd8, 4'b1100, 32'hCAFE_2222);
      tick();
      rd(0, 5'd8);
      expect_rd("conflict_disjoint", 0, 32'hCAFE_BEEF, 1'b0);
      drain();

      // scoreboard
      @(negedge clk);
      bset = 1'b1; bset_addr = 5'd9;
      tick();
      rd(0, 5'd9);
      expect_rd("busy_set", 0, 32'd9, 1'b1);
      drain();
      @(negedge clk);
      wr(0, 5'd9, 4'hF, 32'h0000_0099);
      bset = 1'b1; bset_addr = 5'd9;
      tick();
      expect_rd("set_beats_clear", 0, 32'h99, 1'b1);
      drain();
      @(negedge clk);
      wr(1, 5'd9, 4'hF, 32'h0000_0999);
      tick();
      expect_rd("busy_clear", 0, 32'h999, 1'b0);
      drain();
      @(negedge clk);
      bset = 1'b1; bset_addr = 5'd0;
      tick();
      rd(1, 5'd0);
      expect_rd("busy_reg0", 1, '0, 1'b0);
      drain();

      // zero-strobe retire
      @(negedge clk);
      bset = 1'b1; bset_addr = 5'd10;
      tick();
      rd(1, 5'd10);
      expect_rd("busy_set10", 1, 32'd10, 1'b1);
      drain();
      @(negedge clk);
      wr(0, 5'd10, 4'h0, 32'hDEAD_BEEF);
      tick();
      expect_rd("zero_strobe", 1, 32'd10, 1'b0);
      drain();

      // same-cycle forwarding behaviour
      @(negedge clk);
      rd(1, 5'd3);
      wr(0, 5'd3, 4'hF, 32'h1234_5678);
`ifdef RF_BYPASS_EN
      by_exp = 32'h1234_5678;
`else
      by_exp = 32'd3;
`endif
      expect_rd("same_cycle_rd", 1, by_exp, 1'b0);
      drain();
      tick();
      expect_rd("after_write_rd", 1, 32'h1234_5678, 1'b0);
      drain();

      // asynchronous reset between edges
      @(negedge clk);
      bset = 1'b1; bset_addr = 5'd12;
      tick();
      rd(0, 5'd12); rd(1, 5'd5);
      expect_rd("pre_rst_busy", 0, 32'd12, 1'b1);
      expect_rd("pre_rst_data", 1, 32'hAA22_CC44, 1'b0);
      drain();
      @(negedge clk);
      #2 rst_n = 1'b0;
      expect_rd("async_rst", 0, '0, 1'b0);
      expect_rd("async_rst", 1, '0, 1'b0);
      drain();

      // write attempted while in reset is dropped
      wr(0, 5'd12, 4'hF, 32'h5555_5555);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      expect_rd("rst_abort_wr", 0, '0, 1'b0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
